// File: rtl/regfile_access_unit.sv
// regfile_access_unit
//
// Issue-side front end for the 8x16 register file. It accepts one operand
// request per transaction, reads both sources from the register file (with
// bypass from a same-cycle writeback), and holds them for the execute stage
// on a valid/ready handshake. A per-register pending scoreboard stalls issue
// on RAW/WAW hazards. Writeback traffic is passed straight to the RF write port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   IssueValid/IssueReady    request handshake
//   IssueSrc1/2, IssueDst    source/destination register indices
//   IssueDstEn               instruction writes IssueDst
//   ReadReg1/2, ReadData1/2  register file read ports (combinational read)
//   RegWrite/WriteReg/WriteData  register file write port
//   WbValid/WbReg/WbData     writeback input (always accepted)
//   OpValid/OpReady          operand handshake to execute
//   OpA/OpB/OpDst/OpDstEn    operand payload
//   PendingMask              scoreboard, bit i = register i has a write in flight
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a hazard-free request
// READ  | RF addressed from latched sources; operands captured this cycle
// HOLD  | OpValid high, payload stable until OpReady
module regfile_access_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IssueValid,
    output logic                     IssueReady,
    input  logic [ADDR_W-1:0]        IssueSrc1,
    input  logic [ADDR_W-1:0]        IssueSrc2,
    input  logic [ADDR_W-1:0]        IssueDst,
    input  logic                     IssueDstEn,
    output logic [ADDR_W-1:0]        ReadReg1,
    output logic [ADDR_W-1:0]        ReadReg2,
    input  logic [DATA_W-1:0]        ReadData1,
    input  logic [DATA_W-1:0]        ReadData2,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        WriteReg,
    output logic [DATA_W-1:0]        WriteData,
    input  logic                     WbValid,
    input  logic [ADDR_W-1:0]        WbReg,
    input  logic [DATA_W-1:0]        WbData,
    output logic                     OpValid,
    input  logic                     OpReady,
    output logic [DATA_W-1:0]        OpA,
    output logic [DATA_W-1:0]        OpB,
    output logic [ADDR_W-1:0]        OpDst,
    output logic                     OpDstEn,
    output logic [(2**ADDR_W)-1:0]   PendingMask
);

    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
    logic              dst_en_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, op_a_nxt, op_b_nxt;
    logic              op_valid_q;
    logic [NREG-1:0]   pending, pending_set, pending_clr;
    logic              hazard, accept, capture, release_op;

    // Hazard looks at the registered scoreboard only, so a clearing
    // writeback makes a stalled request acceptable one cycle later.
    assign hazard     = pending[IssueSrc1] | pending[IssueSrc2]
                      | (IssueDstEn & pending[IssueDst]);
    assign IssueReady = (state == IDLE) & ~hazard & ~rst;
    assign accept     = IssueValid & IssueReady;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        capture    = 1'b0;
        release_op = 1'b0;
        unique case (state)
            IDLE: if (accept) state_nxt = READ;
            READ: begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: if (OpReady) begin
                release_op = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    always_comb begin
        pending_set = '0;
        pending_clr = '0;
        if (accept && IssueDstEn) pending_set[IssueDst] = 1'b1;
        if (WbValid)              pending_clr[WbReg]    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~pending_clr) | pending_set;
    end

    // Same-cycle writeback bypasses the RF, which still holds the old value.
    always_comb begin
        op_a_nxt = (WbValid && (WbReg == src1_q)) ? WbData : ReadData1;
        op_b_nxt = (WbValid && (WbReg == src2_q)) ? WbData : ReadData2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src1_q     <= '0;
            src2_q     <= '0;
            dst_q      <= '0;
            dst_en_q   <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                src1_q   <= IssueSrc1;
                src2_q   <= IssueSrc2;
                dst_q    <= IssueDst;
                dst_en_q <= IssueDstEn;
            end
            if (capture) begin
                op_a_q     <= op_a_nxt;
                op_b_q     <= op_b_nxt;
                op_valid_q <= 1'b1;
            end else if (release_op) begin
                op_valid_q <= 1'b0;
            end
        end
    end

    assign ReadReg1    = src1_q;
    assign ReadReg2    = src2_q;
    assign OpA         = op_a_q;
    assign OpB         = op_b_q;
    assign OpDst       = dst_q;
    assign OpDstEn     = dst_en_q;
    assign OpValid     = op_valid_q;
    assign PendingMask = pending;

    assign RegWrite  = WbValid & ~rst;
    assign WriteReg  = WbReg;
    assign WriteData = WbData;

endmodule

// File: tb/tb_regfile_access_unit.sv
// Bench for regfile_access_unit: a small register file model sits on the
// read/write ports; directed issues push hand-computed operands into a
// scoreboard that a separate monitor pops at each operand handshake.
module tb_regfile_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        IssueValid, IssueReady;
    logic [2:0]  IssueSrc1, IssueSrc2, IssueDst;
    logic        IssueDstEn;
    logic [2:0]  ReadReg1, ReadReg2;
    logic [15:0] ReadData1, ReadData2;
    logic        RegWrite;
    logic [2:0]  WriteReg;
    logic [15:0] WriteData;
    logic        WbValid;
    logic [2:0]  WbReg;
    logic [15:0] WbData;
    logic        OpValid, OpReady;
    logic [15:0] OpA, OpB;
    logic [2:0]  OpDst;
    logic        OpDstEn;
    logic [7:0]  PendingMask;

    regfile_access_unit #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .IssueValid(IssueValid), .IssueReady(IssueReady),
        .IssueSrc1(IssueSrc1), .IssueSrc2(IssueSrc2),
        .IssueDst(IssueDst), .IssueDstEn(IssueDstEn),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .WbValid(WbValid), .WbReg(WbReg), .WbData(WbData),
        .OpValid(OpValid), .OpReady(OpReady),
        .OpA(OpA), .OpB(OpB), .OpDst(OpDst), .OpDstEn(OpDstEn),
        .PendingMask(PendingMask)
    );

    always #5 clk = ~clk;

    logic [15:0] rf [8] = '{16'h0A0A, 16'h1234, 16'h1111, 16'h2222,
                            16'h4444, 16'h5555, 16'h6666, 16'h7070};
    always @(posedge clk) if (RegWrite) rf[WriteReg] <= WriteData;
    assign ReadData1 = rf[ReadReg1];
    assign ReadData2 = rf[ReadReg2];

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dst;
        logic        den;
        int          vcyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on OpValid rise, payload on handshake.
    initial begin : mon
        exp_t e;
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
                continue;
            end
            if (OpValid && !prev_v) begin
                if (sb.size() == 0) chk("op_unexpected_qdepth", sb.size(), 1);
                else                chk("op_latency_cycle", cycle, sb[0].vcyc);
            end
            prev_v = OpValid;
            if (OpValid && OpReady && sb.size() > 0) begin
                e = sb.pop_front();
                chk("op_a",      OpA,     e.a);
                chk("op_b",      OpB,     e.b);
                chk("op_dst",    OpDst,   e.dst);
                chk("op_dst_en", OpDstEn, e.den);
            end
        end
    end

    // Called just after a posedge; returns #1 after the accepting edge (READ cycle).
    task automatic issue(input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] d,
                         input logic den, input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        bit ok = 1'b0;
        IssueSrc1 = s1; IssueSrc2 = s2; IssueDst = d; IssueDstEn = den;
        IssueValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (IssueReady) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("issue_timeout_ready", 0, 1);
            IssueValid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        IssueValid = 1'b0;
        e.a = ea; e.b = eb; e.dst = d; e.den = den;
        e.vcyc = cycle + 1;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("done_timeout_qdepth", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; OpReady = 1'b1;
        IssueValid = 1'b1; IssueSrc1 = 3'd0; IssueSrc2 = 3'd0; IssueDst = 3'd0; IssueDstEn = 1'b0;
        WbValid = 1'b1; WbReg = 3'd1; WbData = 16'hFFFF;

        // Reset
        @(posedge clk);
        @(negedge clk);
        chk("rst_issue_ready", IssueReady, 0);
        chk("rst_reg_write",   RegWrite,   0);
        @(posedge clk); #1;
        rst = 1'b0; IssueValid = 1'b0; WbValid = 1'b0;
        @(negedge clk);
        chk("rst_op_valid", OpValid,     0);
        chk("rst_pending",  PendingMask, 0);
        chk("rst_op_a",     OpA,         0);
        chk("rst_read_reg1", ReadReg1,   0);
        @(posedge clk); #1;

        // Basic issue
        issue(3'd2, 3'd3, 3'd4, 1'b1, 16'h1111, 16'h2222);
        @(negedge clk);
        chk("read_pending", PendingMask, 8'h10);
        chk("read_reg1",    ReadReg1,    2);
        chk("read_reg2",    ReadReg2,    3);
        wait_done();

        // RAW stall cleared by writeback
        IssueSrc1 = 3'd4; IssueSrc2 = 3'd0; IssueDst = 3'd1; IssueDstEn = 1'b0; IssueValid = 1'b1;
        @(negedge clk);
        chk("raw_stall_ready", IssueReady, 0);
        @(posedge clk); #1;
        WbValid = 1'b1; WbReg = 3'd4; WbData = 16'hBEEF;
        @(negedge clk);
        chk("wb_reg_write",  RegWrite,  1);
        chk("wb_write_reg",  WriteReg,  4);
        chk("wb_write_data", WriteData, 16'hBEEF);
        chk("wb_same_cycle_ready", IssueReady, 0);
        @(posedge clk); #1;
        WbValid = 1'b0;
        @(negedge clk);
        chk("wb_clear_pending", PendingMask, 0);
        chk("raw_release_ready", IssueReady, 1);
        IssueValid = 1'b0;
        @(posedge clk); #1;
        issue(3'd4, 3'd0, 3'd1, 1'b0, 16'hBEEF, 16'h0A0A);
        wait_done();

        // Bypass during READ on Src2, then on Src1
        issue(3'd1, 3'd5, 3'd0, 1'b0, 16'h1234, 16'h5A5A);
        WbValid = 1'b1; WbReg = 3'd5; WbData = 16'h5A5A;
        @(posedge clk); #1;
        WbValid = 1'b0;
        wait_done();
        issue(3'd7, 3'd1, 3'd0, 1'b0, 16'h7777, 16'h1234);
        WbValid = 1'b1; WbReg = 3'd7; WbData = 16'h7777;
        @(posedge clk); #1;
        WbValid = 1'b0;
        wait_done();

        // Backpressure in HOLD
        OpReady = 1'b0;
        issue(3'd2, 3'd3, 3'd6, 1'b1, 16'h1111, 16'h2222);
        @(posedge clk); #1;
        IssueSrc1 = 3'd0; IssueSrc2 = 3'd0; IssueDst = 3'd0; IssueDstEn = 1'b0; IssueValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hold_op_valid", OpValid, 1);
            chk("hold_op_a",     OpA,     16'h1111);
            chk("hold_op_b",     OpB,     16'h2222);
            chk("hold_op_dst",   OpDst,   6);
            chk("hold_issue_ready", IssueReady, 0);
            @(posedge clk); #1;
        end
        OpReady = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_op_valid",    OpValid,    0);
        chk("release_issue_ready", IssueReady, 1);
        IssueValid = 1'b0;
        chk("release_sb_empty", sb.size(), 0);
        @(posedge clk); #1;

        // WAW stall on Pending[6], accepted once DstEn drops
        IssueSrc1 = 3'd0; IssueSrc2 = 3'd1; IssueDst = 3'd6; IssueDstEn = 1'b1; IssueValid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("waw_stall_ready", IssueReady, 0);
            @(posedge clk); #1;
        end
        issue(3'd0, 3'd1, 3'd6, 1'b0, 16'h0A0A, 16'h1234);
        wait_done();
        WbValid = 1'b1; WbReg = 3'd6; WbData = 16'h6060;
        @(posedge clk); #1;
        WbValid = 1'b0;
        @(negedge clk);
        chk("waw_clear_pending", PendingMask, 0);
        @(posedge clk); #1;

        // Writeback to a non-pending register
        WbValid = 1'b1; WbReg = 3'd0; WbData = 16'h0B0B;
        @(negedge clk);
        chk("nonpend_reg_write", RegWrite, 1);
        @(posedge clk); #1;
        WbValid = 1'b0;
        @(negedge clk);
        chk("nonpend_pending", PendingMask, 0);
        @(posedge clk); #1;

        // Same-cycle set and clear of Pending[3]: set wins
        WbValid = 1'b1; WbReg = 3'd3; WbData = 16'h3030;
        issue(3'd1, 3'd2, 3'd3, 1'b1, 16'h1234, 16'h1111);
        WbValid = 1'b0;
        @(negedge clk);
        chk("setwins_pending", PendingMask, 8'h08);
        wait_done();

        // Reset while in HOLD
        OpReady = 1'b0;
        issue(3'd0, 3'd1, 3'd4, 1'b1, 16'h0B0B, 16'h1234);
        @(posedge clk); #1;
        @(negedge clk);
        chk("prerst_pending",  PendingMask, 8'h18);
        chk("prerst_op_valid", OpValid,     1);
        @(posedge clk); #1;
        sb.delete();
        rst = 1'b1;
        IssueSrc1 = 3'd0; IssueSrc2 = 3'd1; IssueDst = 3'd2; IssueDstEn = 1'b0; IssueValid = 1'b1;
        @(negedge clk);
        chk("midrst_issue_ready", IssueReady, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_op_valid",  OpValid,     0);
        chk("postrst_pending",   PendingMask, 0);
        chk("postrst_op_a",      OpA,         0);
        chk("postrst_op_b",      OpB,         0);
        chk("postrst_op_dst",    OpDst,       0);
        chk("postrst_op_dst_en", OpDstEn,     0);
        chk("postrst_read_reg1", ReadReg1,    0);
        chk("postrst_read_reg2", ReadReg2,    0);
        chk("postrst_issue_ready", IssueReady, 1);
        IssueValid = 1'b0;
        OpReady = 1'b1;
        @(posedge clk); #1;

        // Normal operation after reset
        issue(3'd3, 3'd4, 3'd5, 1'b1, 16'h3030, 16'hBEEF);
        @(negedge clk);
        chk("final_pending", PendingMask, 8'h20);
        wait_done();
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout actual=%0t required=<20000", $time);
        $fatal(1, "timeout");
    end

endmodule
